// File: rtl/uart_rx.sv
// UART receiver: 1 start bit (low), PAYLOAD_BITS data bits LSB first,
// STOP_BITS stop bits (high), idle high. The asynchronous rx pin is
// synchronised and each bit is sampled at its centre using a cycle counter.
//
// Ports:
//   clk               system clock
//   resetn            synchronous active-low reset
//   uart_rxd          UART receive pin (asynchronous to clk)
//   uart_rx_en        enables start-bit detection (IDLE -> START only)
//   uart_rx_break     one-cycle pulse: framing error with all-zero payload
//   uart_rx_frame_err one-cycle pulse: first stop bit sampled low
//   uart_rx_valid     one-cycle pulse: uart_rx_data holds a new good frame
//   uart_rx_data      last good received payload
module uart_rx #(
    parameter int unsigned BIT_RATE     = 9600,
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic                    uart_rx_break,
    output logic                    uart_rx_frame_err,
    output logic                    uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data
);

    localparam int unsigned CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int unsigned HALF           = CYCLES_PER_BIT / 2;
    localparam int unsigned CW             = 1 + $clog2(CYCLES_PER_BIT);

    // Elaboration-time guard on the frame format.
    if (PAYLOAD_BITS < 1 || PAYLOAD_BITS > 8 || STOP_BITS < 1) begin : g_bad_cfg
        $error("uart_rx: unsupported PAYLOAD_BITS/STOP_BITS");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t                  state_q, state_d;
    logic                    sync1_q, sync2_q;
    logic [CW-1:0]           cyc_q, cyc_d;
    logic [3:0]              bit_q, bit_d;
    logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
    logic [PAYLOAD_BITS-1:0] data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    ferr_q, ferr_d;
    logic                    brk_q, brk_d;

    logic                    rxd_s;
    logic                    half_hit;
    logic                    bit_end;
    logic [PAYLOAD_BITS:0]   shift_cat;
    logic [PAYLOAD_BITS-1:0] shift_in;

    assign rxd_s    = sync2_q;
    assign half_hit = (cyc_q == CW'(HALF - 1));
    assign bit_end  = (cyc_q == CW'(CYCLES_PER_BIT - 1));

    // Shift right with the new bit entering at the MSB (LSB-first line order).
    assign shift_cat = {rxd_s, shift_q};
    assign shift_in  = shift_cat[PAYLOAD_BITS:1];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= S_IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            sync1_q <= uart_rxd;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            brk_q   <= brk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        brk_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                cyc_d = '0;
                if (uart_rx_en && !rxd_s) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                cyc_d = cyc_q + 1'b1;
                if (half_hit) begin
                    cyc_d = '0;
                    // A start bit that is high again at its centre was a glitch.
                    state_d = rxd_s ? S_IDLE : S_DATA;
                end
            end

            S_DATA: begin
                cyc_d = cyc_q + 1'b1;
                if (bit_end) begin
                    cyc_d   = '0;
                    shift_d = shift_in;
                    if (bit_q == 4'(PAYLOAD_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end

            S_STOP: begin
                cyc_d = cyc_q + 1'b1;
                if (bit_end) begin
                    cyc_d = '0;
                    if (rxd_s) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        brk_d   = (shift_q == '0);
                        state_d = S_WAIT_HIGH;
                    end
                end
            end

            S_WAIT_HIGH: begin
                // Holding here keeps a long break from being reported repeatedly.
                cyc_d = '0;
                if (rxd_s) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cyc_d   = '0;
                bit_d   = '0;
            end
        endcase
    end

    assign uart_rx_valid     = valid_q;
    assign uart_rx_frame_err = ferr_q;
    assign uart_rx_break     = brk_q;
    assign uart_rx_data      = data_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 10 clock cycles per bit, 8N1.
// Stimulus pushes the expected event of each frame; a monitor pops and
// compares whenever the receiver raises any of its strobes.
module tb_uart_rx;

    localparam int unsigned CPB = 10;

    logic       clk = 1'b0;
    logic       resetn;
    logic       uart_rxd;
    logic       uart_rx_en;
    logic       uart_rx_break;
    logic       uart_rx_frame_err;
    logic       uart_rx_valid;
    logic [7:0] uart_rx_data;

    uart_rx #(
        .BIT_RATE     (100_000),
        .CLK_HZ       (1_000_000),
        .PAYLOAD_BITS (8),
        .STOP_BITS    (1)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .uart_rxd          (uart_rxd),
        .uart_rx_en        (uart_rx_en),
        .uart_rx_break     (uart_rx_break),
        .uart_rx_frame_err (uart_rx_frame_err),
        .uart_rx_valid     (uart_rx_valid),
        .uart_rx_data      (uart_rx_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         v;
        bit         fe;
        bit         br;
        logic [7:0] d;
        int         t0;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc_cnt = 0;
    logic [7:0] last_good = 8'h00;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input bit ok, input string name, input string detail);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    // Reference model: a good stop bit yields the payload, a low stop bit a
    // framing error, and a framing error on an all-zero payload is a break.
    task automatic expect_frame(input logic [7:0] d, input bit stop_ok, input int t0);
        exp_t e;
        e.v  = stop_ok;
        e.fe = !stop_ok;
        e.br = !stop_ok && (d == 8'h00);
        e.d  = d;
        e.t0 = t0;
        sb.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_ok,
                              input bit expect_it, input bit en_at_stop);
        @(negedge clk);
        uart_rxd = 1'b0;
        if (expect_it) expect_frame(d, stop_ok, cyc_cnt);
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = d[i];
            repeat (CPB) @(negedge clk);
        end
        if (en_at_stop) uart_rx_en = 1'b1;
        uart_rxd = stop_ok;
        repeat (CPB) @(negedge clk);
        uart_rxd = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk(uart_rx_valid == 1'b0, {tag, "_valid"}, $sformatf("got %0b want 0", uart_rx_valid));
        chk(uart_rx_frame_err == 1'b0, {tag, "_ferr"}, $sformatf("got %0b want 0", uart_rx_frame_err));
        chk(uart_rx_break == 1'b0, {tag, "_break"}, $sformatf("got %0b want 0", uart_rx_break));
        chk(uart_rx_data == 8'h00, {tag, "_data"}, $sformatf("got %02h want 00", uart_rx_data));
    endtask

    // Monitor: every strobe cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        if (resetn && (uart_rx_valid || uart_rx_frame_err || uart_rx_break)) begin
            if (sb.size() == 0) begin
                chk(1'b0, "unexpected_event",
                    $sformatf("got v=%0b fe=%0b br=%0b data=%02h want no event",
                              uart_rx_valid, uart_rx_frame_err, uart_rx_break, uart_rx_data));
            end else begin
                exp_t e;
                int   lat;
                e   = sb.pop_front();
                lat = cyc_cnt - e.t0;
                chk({uart_rx_valid, uart_rx_frame_err, uart_rx_break} == {e.v, e.fe, e.br},
                    "event_flags",
                    $sformatf("got v/fe/br=%0b%0b%0b want %0b%0b%0b",
                              uart_rx_valid, uart_rx_frame_err, uart_rx_break, e.v, e.fe, e.br));
                if (e.v) begin
                    chk(uart_rx_data == e.d, "rx_data",
                        $sformatf("got %02h want %02h", uart_rx_data, e.d));
                    last_good = e.d;
                end else begin
                    chk(uart_rx_data == last_good, "data_hold_on_err",
                        $sformatf("got %02h want %02h", uart_rx_data, last_good));
                end
                chk(lat >= 95 && lat <= 100, "latency",
                    $sformatf("got %0d cycles want 95..100", lat));
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got no completion within 60000 cycles want completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        bit         ok;

        resetn     = 1'b0;
        uart_rxd   = 1'b1;
        uart_rx_en = 1'b1;
        idle(3);
        check_reset_outputs("reset");
        resetn = 1'b1;
        idle(10);

        // Good frames.
        send_frame(8'h55, 1'b1, 1'b1, 1'b0); idle(15);
        send_frame(8'hA3, 1'b1, 1'b1, 1'b0); idle(15);
        send_frame(8'h00, 1'b1, 1'b1, 1'b0); idle(15);

        // Framing error with non-zero payload, then recovery.
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0); idle(15);
        send_frame(8'h81, 1'b1, 1'b1, 1'b0); idle(15);

        // Line held low for 300 cycles: a single break event.
        @(negedge clk);
        uart_rxd = 1'b0;
        expect_frame(8'h00, 1'b0, cyc_cnt);
        idle(300);
        uart_rxd = 1'b1;
        idle(20);
        send_frame(8'h7E, 1'b1, 1'b1, 1'b0); idle(15);

        // 3-cycle glitch while idle.
        @(negedge clk);
        uart_rxd = 1'b0;
        idle(3);
        uart_rxd = 1'b1;
        idle(30);
        send_frame(8'h12, 1'b1, 1'b1, 1'b0); idle(15);

        // Receiver disabled; enable arrives during the stop bit of 0x44.
        uart_rx_en = 1'b0;
        send_frame(8'h99, 1'b1, 1'b0, 1'b0); idle(15);
        send_frame(8'h44, 1'b1, 1'b0, 1'b1); idle(15);
        send_frame(8'hF0, 1'b1, 1'b1, 1'b0); idle(15);

        // Reset pulse during data bit 4 of 0xAA; the far end is reset too,
        // so the line returns to idle for the rest of that frame.
        @(negedge clk);
        uart_rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            uart_rxd = 8'hAA >> i;
            repeat (CPB) @(negedge clk);
        end
        uart_rxd = 1'b0;
        idle(5);
        resetn = 1'b0;
        @(negedge clk);
        check_reset_outputs("midframe_reset");
        resetn    = 1'b1;
        last_good = 8'h00;
        uart_rxd  = 1'b1;
        idle(40);
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0); idle(15);

        // Randomised frames, including back-to-back and bad stop bits.
        for (int n = 0; n < 12; n++) begin
            rd = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) rd = 8'h00;
            ok = ($urandom_range(0, 3) != 0);
            send_frame(rd, ok, 1'b1, 1'b0);
            idle($urandom_range(0, 12));
        end

        idle(200);
        chk(sb.size() == 0, "pending_events",
            $sformatf("got %0d outstanding want 0", sb.size()));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
